// File: rtl/sirv_debug_rom_arb.sv
// Two-port arbiter and one-cycle-latency responder in front of the 29-word debug ROM.
// Define SIRV_DEBUG_ROM_ARB_RR_EN to get round-robin arbitration; the default is fixed priority, i0 > i1.
module sirv_debug_rom_arb #(
  parameter int ROM_WORDS = 29
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        i0_icb_cmd_valid,
  output logic        i0_icb_cmd_ready,
  input  logic [6:0]  i0_icb_cmd_addr,
  input  logic        i0_icb_cmd_read,
  output logic        i0_icb_rsp_valid,
  input  logic        i0_icb_rsp_ready,
  output logic [31:0] i0_icb_rsp_rdata,
  output logic        i0_icb_rsp_err,
  input  logic        i1_icb_cmd_valid,
  output logic        i1_icb_cmd_ready,
  input  logic [6:0]  i1_icb_cmd_addr,
  input  logic        i1_icb_cmd_read,
  output logic        i1_icb_rsp_valid,
  input  logic        i1_icb_rsp_ready,
  output logic [31:0] i1_icb_rsp_rdata,
  output logic        i1_icb_rsp_err,
  output logic [4:0]  rom_addr,
  input  logic [31:0] rom_dout,
  output logic        arb_busy
);

  typedef enum logic {IDLE, RSP} state_t;

  localparam logic [5:0] ROM_LIMIT = 6'(ROM_WORDS);

  state_t      state, state_nxt;
  logic        owner;
  logic [31:0] rdata_q;
  logic        err_q;
  logic        grant0, grant1;
  logic        rsp_pending, rsp_hsk, cmd_open, cmd_hsk;
  logic [6:0]  sel_addr;
  logic        sel_read, sel_bad;

`ifdef SIRV_DEBUG_ROM_ARB_RR_EN
  // rr_ptr is the last-granted port; on a tie the other port wins.
  logic rr_ptr;

  assign grant0 = i0_icb_cmd_valid & (~i1_icb_cmd_valid | rr_ptr);
  assign grant1 = i1_icb_cmd_valid & (~i0_icb_cmd_valid | ~rr_ptr);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) rr_ptr <= 1'b1;
    else if (cmd_hsk) rr_ptr <= grant1;
  end
`else
  assign grant0 = i0_icb_cmd_valid;
  assign grant1 = i1_icb_cmd_valid & ~i0_icb_cmd_valid;
`endif

  assign rsp_pending = (state == RSP);
  assign rsp_hsk     = rsp_pending & (owner ? i1_icb_rsp_ready : i0_icb_rsp_ready);
  // A response retiring this cycle frees the slot, allowing back-to-back transactions.
  assign cmd_open    = ~rsp_pending | rsp_hsk;

  assign i0_icb_cmd_ready = grant0 & cmd_open;
  assign i1_icb_cmd_ready = grant1 & cmd_open;
  assign cmd_hsk          = i0_icb_cmd_ready | i1_icb_cmd_ready;

  assign sel_addr = grant1 ? i1_icb_cmd_addr : i0_icb_cmd_addr;
  assign sel_read = grant1 ? i1_icb_cmd_read : i0_icb_cmd_read;
  assign sel_bad  = ~sel_read | (|sel_addr[1:0]) | ({1'b0, sel_addr[6:2]} >= ROM_LIMIT);
  assign rom_addr = (grant0 | grant1) ? sel_addr[6:2] : 5'd0;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (cmd_hsk) state_nxt = RSP;
      RSP:  if (rsp_hsk && !cmd_hsk) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      owner   <= 1'b0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else if (cmd_hsk) begin
      owner   <= grant1;
      rdata_q <= sel_bad ? 32'd0 : rom_dout;
      err_q   <= sel_bad;
    end
  end

  assign i0_icb_rsp_valid = rsp_pending & ~owner;
  assign i1_icb_rsp_valid = rsp_pending & owner;
  assign i0_icb_rsp_rdata = rdata_q;
  assign i1_icb_rsp_rdata = rdata_q;
  assign i0_icb_rsp_err   = err_q;
  assign i1_icb_rsp_err   = err_q;
  assign arb_busy         = rsp_pending | cmd_hsk;

endmodule

// File: tb/tb_sirv_debug_rom_arb.sv
// Bench for sirv_debug_rom_arb: transaction-level model checked every cycle, plus directed literal checks.
module tb_sirv_debug_rom_arb;
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        i0_icb_cmd_valid, i0_icb_cmd_ready, i0_icb_cmd_read, i0_icb_rsp_valid, i0_icb_rsp_ready, i0_icb_rsp_err;
  logic        i1_icb_cmd_valid, i1_icb_cmd_ready, i1_icb_cmd_read, i1_icb_rsp_valid, i1_icb_rsp_ready, i1_icb_rsp_err;
  logic [6:0]  i0_icb_cmd_addr, i1_icb_cmd_addr;
  logic [31:0] i0_icb_rsp_rdata, i1_icb_rsp_rdata;
  logic [4:0]  rom_addr;
  logic [31:0] rom_dout;
  logic        arb_busy;
  logic [31:0] rom [32];

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;
  assign rom_dout = rom[rom_addr];

  sirv_debug_rom_arb dut (
    .clock(clock), .reset(reset),
    .i0_icb_cmd_valid(i0_icb_cmd_valid), .i0_icb_cmd_ready(i0_icb_cmd_ready),
    .i0_icb_cmd_addr(i0_icb_cmd_addr), .i0_icb_cmd_read(i0_icb_cmd_read),
    .i0_icb_rsp_valid(i0_icb_rsp_valid), .i0_icb_rsp_ready(i0_icb_rsp_ready),
    .i0_icb_rsp_rdata(i0_icb_rsp_rdata), .i0_icb_rsp_err(i0_icb_rsp_err),
    .i1_icb_cmd_valid(i1_icb_cmd_valid), .i1_icb_cmd_ready(i1_icb_cmd_ready),
    .i1_icb_cmd_addr(i1_icb_cmd_addr), .i1_icb_cmd_read(i1_icb_cmd_read),
    .i1_icb_rsp_valid(i1_icb_rsp_valid), .i1_icb_rsp_ready(i1_icb_rsp_ready),
    .i1_icb_rsp_rdata(i1_icb_rsp_rdata), .i1_icb_rsp_err(i1_icb_rsp_err),
    .rom_addr(rom_addr), .rom_dout(rom_dout), .arb_busy(arb_busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Model: one outstanding response (port, data, error); the winner of each cycle is chosen from the rules.
  bit          m_pend, m_port, m_err, m_last, m_done, m_acc, m_v0, m_v1;
  logic [31:0] m_rdata;
  int          m_w;
  logic [6:0]  m_a;
  logic        m_rd;

  always @(negedge clock) begin
    if (reset) begin
      m_pend = 0;
      m_last = 1;
    end else begin
      m_v0 = (i0_icb_cmd_valid === 1'b1);
      m_v1 = (i1_icb_cmd_valid === 1'b1);
      m_w = -1;
      if (m_v0 && m_v1) begin
`ifdef SIRV_DEBUG_ROM_ARB_RR_EN
        m_w = m_last ? 0 : 1;
`else
        m_w = 0;
`endif
      end else if (m_v0) m_w = 0;
      else if (m_v1) m_w = 1;
      m_done = m_pend && (m_port ? i1_icb_rsp_ready : i0_icb_rsp_ready);
      m_acc  = (m_w >= 0) && (!m_pend || m_done);
      m_a  = (m_w == 1) ? i1_icb_cmd_addr : i0_icb_cmd_addr;
      m_rd = (m_w == 1) ? i1_icb_cmd_read : i0_icb_cmd_read;

      chk("m_i0_rsp_valid", i0_icb_rsp_valid, m_pend && m_port == 0);
      chk("m_i1_rsp_valid", i1_icb_rsp_valid, m_pend && m_port == 1);
      if (m_pend) begin
        chk("m_rdata", m_port ? i1_icb_rsp_rdata : i0_icb_rsp_rdata, m_rdata);
        chk("m_err", m_port ? i1_icb_rsp_err : i0_icb_rsp_err, m_err);
      end
      chk("m_i0_cmd_ready", i0_icb_cmd_ready, m_acc && m_w == 0);
      chk("m_i1_cmd_ready", i1_icb_cmd_ready, m_acc && m_w == 1);
      chk("m_rom_addr", rom_addr, (m_w < 0) ? 0 : m_a / 4);
      chk("m_arb_busy", arb_busy, m_pend || m_acc);

      if (m_acc) begin
        m_pend  = 1;
        m_port  = (m_w == 1);
        m_last  = (m_w == 1);
        m_err   = !m_rd || (m_a % 4 != 0) || (m_a / 4 >= 29);
        m_rdata = m_err ? 32'd0 : rom[m_a / 4];
      end else if (m_done) begin
        m_pend = 0;
      end
    end
  end

  task automatic tick();
    @(posedge clock); #1;
  endtask

  task automatic at_neg();
    @(negedge clock); #1;
  endtask

  task automatic idle_inputs();
    i0_icb_cmd_valid = 0; i0_icb_cmd_addr = 0; i0_icb_cmd_read = 1; i0_icb_rsp_ready = 1;
    i1_icb_cmd_valid = 0; i1_icb_cmd_addr = 0; i1_icb_cmd_read = 1; i1_icb_rsp_ready = 1;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1;
    tick(); tick();
    reset = 0;
  endtask

  task automatic rd(input bit p, input logic [6:0] a, input logic r,
                    input logic [31:0] exp_d, input logic exp_e, input string name);
    idle_inputs();
    if (p) begin i1_icb_cmd_valid = 1; i1_icb_cmd_addr = a; i1_icb_cmd_read = r; end
    else   begin i0_icb_cmd_valid = 1; i0_icb_cmd_addr = a; i0_icb_cmd_read = r; end
    at_neg();
    chk({name, "_ready"}, p ? i1_icb_cmd_ready : i0_icb_cmd_ready, 1);
    tick();
    idle_inputs();
    at_neg();
    chk({name, "_valid"}, p ? i1_icb_rsp_valid : i0_icb_rsp_valid, 1);
    chk({name, "_rdata"}, p ? i1_icb_rsp_rdata : i0_icb_rsp_rdata, exp_d);
    chk({name, "_err"}, p ? i1_icb_rsp_err : i0_icb_rsp_err, exp_e);
    tick();
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rom[i] = 32'ha5000000 | (i * 32'h00010101);
    rom[0]  = 32'h03c0006f;
    rom[2]  = 32'hfff00413;
    rom[21] = 32'h40000067;
    rom[28] = 32'hfe1ff06f;
    idle_inputs();
    tick();
    chk("rst_i0_valid", i0_icb_rsp_valid, 0);
    chk("rst_i1_valid", i1_icb_rsp_valid, 0);
    chk("rst_rdata", i0_icb_rsp_rdata, 0);
    chk("rst_err", i1_icb_rsp_err, 0);
    chk("rst_busy", arb_busy, 0);
    tick();
    reset = 0;
    tick();

    rd(0, 7'h00, 1, 32'h03c0006f, 0, "i0_w0");
    rd(1, 7'h54, 1, 32'h40000067, 0, "i1_w21");
    rd(1, 7'h70, 1, 32'hfe1ff06f, 0, "i1_w28");
    rd(0, 7'h74, 1, 32'h0, 1, "i0_w29");
    rd(1, 7'h00, 0, 32'h0, 1, "i1_write");
    rd(0, 7'h02, 1, 32'h0, 1, "i0_misalign");
    at_neg();
    chk("idle_rom_addr", rom_addr, 0);
    tick();

    // Both ports continuously valid
    do_reset();
    i0_icb_cmd_valid = 1; i0_icb_cmd_addr = 7'h00;
    i1_icb_cmd_valid = 1; i1_icb_cmd_addr = 7'h08;
    for (int k = 0; k < 4; k++) begin
      at_neg();
`ifdef SIRV_DEBUG_ROM_ARB_RR_EN
      chk("tie_i0_ready", i0_icb_cmd_ready, (k % 2) == 0);
      chk("tie_i1_ready", i1_icb_cmd_ready, (k % 2) == 1);
`else
      chk("tie_i0_ready", i0_icb_cmd_ready, 1);
      chk("tie_i1_ready", i1_icb_cmd_ready, 0);
`endif
      tick();
    end
    idle_inputs();
    tick(); tick();

    // Backpressure with a queued i1 command
    i0_icb_cmd_valid = 1; i0_icb_cmd_addr = 7'h08; i0_icb_rsp_ready = 0;
    at_neg();
    chk("bp_accept", i0_icb_cmd_ready, 1);
    tick();
    i0_icb_cmd_valid = 0;
    i1_icb_cmd_valid = 1; i1_icb_cmd_addr = 7'h70;
    for (int k = 0; k < 3; k++) begin
      at_neg();
      chk("bp_valid", i0_icb_rsp_valid, 1);
      chk("bp_rdata", i0_icb_rsp_rdata, 32'hfff00413);
      chk("bp_err", i0_icb_rsp_err, 0);
      chk("bp_i0_ready", i0_icb_cmd_ready, 0);
      chk("bp_i1_ready", i1_icb_cmd_ready, 0);
      tick();
    end
    i0_icb_rsp_ready = 1;
    at_neg();
    chk("bp_release_i1_ready", i1_icb_cmd_ready, 1);
    tick();
    i1_icb_cmd_valid = 0;
    at_neg();
    chk("bp_i1_valid", i1_icb_rsp_valid, 1);
    chk("bp_i1_rdata", i1_icb_rsp_rdata, 32'hfe1ff06f);
    tick(); tick();

    // Reset while a response is held
    i0_icb_cmd_valid = 1; i0_icb_cmd_addr = 7'h08; i0_icb_rsp_ready = 0;
    tick();
    i0_icb_cmd_valid = 0;
    at_neg();
    chk("rr_pending", i0_icb_rsp_valid, 1);
    reset = 1;
    #1;
    chk("async_clear", i0_icb_rsp_valid, 0);
    tick(); tick();
    reset = 0;
    for (int k = 0; k < 3; k++) begin
      at_neg();
      chk("no_stale_i0", i0_icb_rsp_valid, 0);
      chk("no_stale_i1", i1_icb_rsp_valid, 0);
      tick();
    end
    rd(0, 7'h08, 1, 32'hfff00413, 0, "post_rst_w2");

    // Random traffic checked by the model
    for (int c = 0; c < 3000; c++) begin
      if (c == 1500) begin
        reset = 1;
        tick(); tick();
        reset = 0;
      end
      i0_icb_cmd_valid = ($urandom_range(3) != 0);
      i1_icb_cmd_valid = ($urandom_range(3) != 0);
      i0_icb_cmd_addr  = ($urandom_range(7) == 0) ? 7'($urandom_range(127)) : {5'($urandom_range(28)), 2'b00};
      i1_icb_cmd_addr  = ($urandom_range(7) == 0) ? 7'($urandom_range(127)) : {5'($urandom_range(28)), 2'b00};
      i0_icb_cmd_read  = ($urandom_range(9) != 0);
      i1_icb_cmd_read  = ($urandom_range(9) != 0);
      i0_icb_rsp_ready = ($urandom_range(3) != 0);
      i1_icb_rsp_ready = ($urandom_range(3) != 0);
      tick();
    end
    idle_inputs();
    tick(); tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
